sys_arr_gemm: RTL

- Output-stationary ROWS x COLS systolic GEMM engine computing C = A(ROWS x K) * B(K x COLS), or C += A*B in accumulate mode.
- Successor to the fixed square array: rectangular shape, run-time inner dimension K, streamed operand vectors with valid/ready, signed saturating accumulation, and row-serial result drain with backpressure.
- Sits between the operand-fetch DMA (upstream) and the result writeback buffer (downstream).

---
 rtl/sys_arr_gemm.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/sys_arr_gemm.sv
// Output-stationary ROWS x COLS systolic GEMM engine: skewed operand injection,
// signed saturating accumulation and row-serial result drain with backpressure.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting k_len operand beats (in_ready high)
// FLUSH | letting the last beat ripple down to the far-corner PE
// DRAIN | presenting accumulator rows 0..ROWS-1 to the writeback buffer
module sys_arr_gemm #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_MAX      = 16,
    localparam int KW        = $clog2(K_MAX + 1),
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       accum,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_col,
    input  logic [COLS*DATA_WIDTH-1:0] b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  out_row,
    output logic [RW-1:0]              out_row_idx,
    output logic                       busy,
    output logic                       done
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int FW = $clog2(ROWS + COLS);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
    localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k_lat;
    logic [KW-1:0]   beat_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [RW-1:0]   row;
    logic            beat;
    logic            clr;
    logic            last_row;

    // a_h/v_h: A operand and tag entering PE(i,j) from the left; b_v: B entering from above
    logic signed [DW-1:0] a_h    [ROWS][COLS];
    logic                 v_h    [ROWS][COLS];
    logic signed [DW-1:0] b_v    [ROWS][COLS];
    logic signed [AW-1:0] acc_arr[ROWS][COLS];

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        beat = 1'b0;
        clr = 1'b0;
        last_row = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr = !accum;
                    state_nx = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                beat = in_valid;
                if (in_valid && (beat_cnt == k_lat - KW'(1)))
                    state_nx = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == '0)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (row == RW'(ROWS - 1))) begin
                    last_row = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row       <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= last_row;
            if (state == IDLE && start) begin
                k_lat    <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            // flush timer counts down to terminal count 0
            if (state == LOAD && state_nx == FLUSH)
                flush_cnt <= FLUSH_LAST;
            else if (state == FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - FW'(1);
            if (state == DRAIN && out_ready)
                row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
        end
    end

    assign busy        = (state != IDLE);
    assign out_row_idx = row;

    // Accumulators are quiescent in DRAIN, so the muxed row holds while stalled
    always_comb begin
        out_row = '0;
        if (state == DRAIN) begin
            for (int j = 0; j < COLS; j++)
                out_row[j*AW +: AW] = acc_arr[row][j];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_col[DW-1:0];
            assign v_h[0][0] = beat;
        end else begin : g_dly
            logic signed [DW-1:0] d [i];
            logic                 v [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) begin
                        d[k] <= '0;
                        v[k] <= 1'b0;
                    end
                end else begin
                    d[0] <= a_col[i*DW +: DW];
                    v[0] <= beat;
                    for (int k = 1; k < i; k++) begin
                        d[k] <= d[k-1];
                        v[k] <= v[k-1];
                    end
                end
            end
            assign a_h[i][0] = d[i-1];
            assign v_h[i][0] = v[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skew_b
        if (j == 0) begin : g_direct
            assign b_v[0][0] = b_row[DW-1:0];
        end else begin : g_dly
            logic signed [DW-1:0] d [j];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < j; k++)
                        d[k] <= '0;
                end else begin
                    d[0] <= b_row[j*DW +: DW];
                    for (int k = 1; k < j; k++)
                        d[k] <= d[k-1];
                end
            end
            assign b_v[0][j] = d[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic signed [2*DW-1:0] prod;
            logic signed [AW:0]     sum;
            logic signed [AW-1:0]   acc_nx;
            logic signed [AW-1:0]   acc_q;

            always_comb begin
                prod = (2*DW)'(a_h[i][j]) * (2*DW)'(b_v[i][j]);
                sum  = {acc_q[AW-1], acc_q} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
                if (sum[AW] != sum[AW-1])
                    acc_nx = sum[AW] ? SAT_MIN : SAT_MAX;
                else
                    acc_nx = sum[AW-1:0];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    acc_q <= '0;
                else if (clr)
                    acc_q <= '0;
                else if (v_h[i][j])
                    acc_q <= acc_nx;
            end
            assign acc_arr[i][j] = acc_q;

            if (j < COLS - 1) begin : g_fwd_a
                logic signed [DW-1:0] a_q;
                logic                 v_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        a_q <= '0;
                        v_q <= 1'b0;
                    end else begin
                        a_q <= a_h[i][j];
                        v_q <= v_h[i][j];
                    end
                end
                assign a_h[i][j+1] = a_q;
                assign v_h[i][j+1] = v_q;
            end

            if (i < ROWS - 1) begin : g_fwd_b
                logic signed [DW-1:0] b_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)
                        b_q <= '0;
                    else
                        b_q <= b_v[i][j];
                end
                assign b_v[i+1][j] = b_q;
            end
        end
    end
endmodule
